key_scheduler: RTL and testbench

KEY_SCHEDULER -- requirements
Module: key_scheduler

---
 rtl/aes_pkg.sv | 26 ++
 rtl/sbox.sv | 28 ++
 rtl/key_scheduler.sv | 121 ++++++++++++
 tb/tb_key_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: default round count, key schedule FSM states,
// round constants and the RotWord helper.
package aes_pkg;

  localparam int NUM_ROUNDS_DEF = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VALID  = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } ks_state_e;

  // Indexed by the round number being produced (1..10); entry 0 and the
  // entries past 10 are never used by AES-128 and read as zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // [b0,b1,b2,b3] (MSB first) -> [b1,b2,b3,b0]
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box, purely combinational byte lookup. Shared with SubBytes.
module sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  localparam logic [7:0] SBOX_TAB [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign byte_o = SBOX_TAB[byte_i];

endmodule

// File: rtl/key_scheduler.sv
// AES-128 iterative key scheduler: one round key per request, expanded in a
// single EXPAND cycle so a new key is presented two cycles after next_key.
module key_scheduler
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_load,
  input  logic [127:0] cipher_key,
  input  logic         next_key,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         key_valid,
  output logic         key_done
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  ks_state_e    state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   num_q, num_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  // Expansion datapath: works on the currently held round key.
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, t_w;
  logic [31:0] n0, n1, n2, n3;
  logic [3:0]  next_num;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w    = rot_word(w3);
  assign next_num = num_q + 4'd1;

  for (genvar b = 0; b < 4; b++) begin : g_sub
    sbox u_sbox (
      .byte_i (rot_w[b*8 +: 8]),
      .byte_o (sub_w[b*8 +: 8])
    );
  end

  assign t_w = sub_w ^ {RCON[next_num], 24'h0};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  // Next-state and registered-output decode; key_load overrides every state.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    num_d   = num_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (key_load) begin
      state_d = VALID;
      key_d   = cipher_key;
      num_d   = 4'd0;
      valid_d = 1'b1;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_d = 1'b0;
          done_d  = 1'b0;
        end
        VALID: begin
          if (next_key && (num_q < LAST_RND)) begin
            state_d = EXPAND;
            valid_d = 1'b0;
          end
        end
        EXPAND: begin
          key_d   = {n0, n1, n2, n3};
          num_d   = next_num;
          valid_d = 1'b1;
          if (next_num == LAST_RND) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = VALID;
          end
        end
        DONE: begin
          valid_d = 1'b1;
          done_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset clears all schedule progress.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign round_key = key_q;
  assign round_num = num_q;
  assign key_valid = valid_q;
  assign key_done  = done_q;

endmodule

// File: tb/tb_key_scheduler.sv
// Bench for key_scheduler: behavioural schedule model (S-box derived from
// GF(2^8) inverse + affine map), per-cycle compare, directed and random stimulus.
module tb_key_scheduler;

  localparam int NR = 10;

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3  = 128'hdeadbeef0123456789abcdeffedcba98;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         key_load, next_key;
  logic [127:0] cipher_key;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid, key_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_scheduler #(.NUM_ROUNDS(NR)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .key_load   (key_load),
    .cipher_key (cipher_key),
    .next_key   (next_key),
    .round_key  (round_key),
    .round_num  (round_num),
    .key_valid  (key_valid),
    .key_done   (key_done)
  );

  // ---------------- reference model ----------------
  logic [7:0] sb_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] d;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, x);
      sb_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w [4];
    logic [31:0] t;
    logic [31:0] o [4];
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    t = {sb_tab[w[3][23:16]], sb_tab[w[3][15:8]], sb_tab[w[3][7:0]], sb_tab[w[3][31:24]]}
        ^ {rc, 24'h0};
    o[0] = w[0] ^ t;
    for (int i = 1; i < 4; i++) o[i] = w[i] ^ o[i-1];
    return {o[0], o[1], o[2], o[3]};
  endfunction

  // Model: the whole schedule is computed on load; an accepted request
  // leaves the key invalid for one cycle, then the index advances.
  logic [127:0] sched [0:NR];
  int           m_idx = 0;
  bit           m_loaded = 1'b0;
  bit           m_pending = 1'b0;

  always @(posedge clk or negedge n_rst) begin
    logic [7:0] rc;
    if (!n_rst) begin
      m_idx = 0; m_loaded = 1'b0; m_pending = 1'b0;
    end else if (key_load) begin
      sched[0] = cipher_key;
      rc = 8'h01;
      for (int r = 1; r <= NR; r++) begin
        sched[r] = model_expand(sched[r-1], rc);
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      m_idx = 0; m_loaded = 1'b1; m_pending = 1'b0;
    end else if (m_pending) begin
      m_idx = m_idx + 1; m_pending = 1'b0;
    end else if (m_loaded && next_key && m_idx < NR) begin
      m_pending = 1'b1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    logic [127:0] ek;
    logic [3:0]   en;
    logic         ev, ed;
    #1;
    ek = m_loaded ? sched[m_idx] : 128'h0;
    en = 4'(m_idx);
    ev = m_loaded && !m_pending;
    ed = ev && (m_idx == NR);
    checks++;
    if ({round_key, round_num, key_valid, key_done} !== {ek, en, ev, ed}) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t got key=%h num=%0d v=%b d=%b exp key=%h num=%0d v=%b d=%b",
               $time, round_key, round_num, key_valid, key_done, ek, en, ev, ed);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic load(input logic [127:0] k);
    key_load = 1'b1; cipher_key = k;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  task automatic step();
    next_key = 1'b1;
    @(negedge clk);
    next_key = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    key_load = 1'b0; next_key = 1'b0; cipher_key = '0;
    build_sbox();
    #1 n_rst = 1'b0;

    // Pin the model against known FIPS-197 values.
    chk("model_sbox00", 128'(sb_tab[8'h00]), 128'h63);
    chk("model_sbox53", 128'(sb_tab[8'h53]), 128'hed);
    chk("model_k1_r1", model_expand(K1, 8'h01), R1);
    chk("model_zero_r1", model_expand(128'h0, 8'h01), Z1);

    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    // Idle ignores next_key.
    next_key = 1'b1;
    repeat (4) @(negedge clk);
    next_key = 1'b0;
    chk("idle_valid", 128'(key_valid), 128'h0);
    chk("idle_key", round_key, 128'h0);
    chk("idle_num", 128'(round_num), 128'h0);

    // Round 0 and round 1 of the FIPS key.
    load(K1);
    chk("r0_key", round_key, K1);
    chk("r0_num", 128'(round_num), 128'h0);
    chk("r0_valid", 128'(key_valid), 128'h1);
    next_key = 1'b1;
    @(negedge clk);
    next_key = 1'b0;
    chk("expand_gap", 128'(key_valid), 128'h0);
    @(negedge clk);
    chk("r1_key", round_key, R1);
    chk("r1_num", 128'(round_num), 128'h1);

    // Remaining rounds to the end, then an ignored extra request.
    repeat (9) step();
    chk("r10_key", round_key, R10);
    chk("r10_num", 128'(round_num), 128'd10);
    chk("r10_done", 128'(key_done), 128'h1);
    next_key = 1'b1;
    @(negedge clk);
    next_key = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_hold_key", round_key, R10);
    chk("done_hold_num", 128'(round_num), 128'd10);
    chk("done_hold_flags", 128'({key_valid, key_done}), 128'h3);

    // All-zero key.
    load(128'h0);
    step();
    chk("zero_r1", round_key, Z1);

    // key_load and next_key together: load wins, nothing queued.
    key_load = 1'b1; next_key = 1'b1; cipher_key = K2;
    @(negedge clk);
    key_load = 1'b0; next_key = 1'b0;
    chk("ld_nk_key", round_key, K2);
    chk("ld_nk_num", 128'(round_num), 128'h0);
    @(negedge clk);
    chk("ld_nk_noqueue", 128'({round_num, key_valid}), 128'h1);

    // key_load during EXPAND abandons the expansion.
    next_key = 1'b1;
    @(negedge clk);
    next_key = 1'b0;
    load(K3);
    chk("ld_exp_key", round_key, K3);
    chk("ld_exp_num", 128'(round_num), 128'h0);
    @(negedge clk);
    chk("ld_exp_hold", round_key, K3);

    // Reset mid-schedule.
    load(K1);
    repeat (5) step();
    chk("r5_num", 128'(round_num), 128'd5);
    n_rst = 1'b0;
    #1;
    chk("rst_async", {round_key[123:0], round_num}, 128'h0);
    chk("rst_flags", 128'({key_valid, key_done}), 128'h0);
    @(negedge clk);
    n_rst = 1'b1;
    next_key = 1'b1;
    repeat (3) @(negedge clk);
    next_key = 1'b0;
    chk("post_rst_idle", 128'({key_valid, round_num}), 128'h0);
    chk("post_rst_key", round_key, 128'h0);

    // Randomized phase, checked by the per-cycle compare.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n_rst      = ($urandom_range(0, 249) != 0);
      key_load   = ($urandom_range(0, 24) == 0);
      next_key   = ($urandom_range(0, 2) != 0);
      cipher_key = ($urandom_range(0, 9) == 0) ? 128'h0
                   : {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    n_rst = 1'b1; key_load = 1'b0; next_key = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
